// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM encoding, default width
// and the step-counter width helper.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// EX-stage <-> divider handshake: request/operands/flush in, status/results out.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor, flush,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor, flush,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor through a ripple carry chain, keep or restore.
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_dq_msb,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q_bit
);

  // The remainder's top bit is kept in the shift so that unsigned divisors
  // above 2^(WIDTH-1) still divide exactly; this is a (WIDTH+1)-bit subtract.
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH+1:0] w_c;
  logic [WIDTH-1:0] w_s;

  assign w_a = {i_rem, i_dq_msb};
  assign w_b = ~{1'b0, i_dvs};

  always_comb begin
    w_c    = '0;
    w_c[0] = 1'b1;
    for (int i = 0; i <= WIDTH; i++) begin
      w_c[i+1] = (w_a[i] & w_b[i]) | (w_c[i] & (w_a[i] ^ w_b[i]));
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum
      assign w_s[gi] = w_a[gi] ^ w_b[gi] ^ w_c[gi];
    end
  endgenerate

  // Carry out of the top bit means no borrow: the divisor fits.
  assign o_q_bit = w_c[WIDTH+1];
  assign o_rem   = o_q_bit ? w_s : w_a[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: quotient to LO, remainder
// to HI, WIDTH+2 cycles from start to the done pulse.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);

  localparam int CNT_W = (WIDTH == DIV_WIDTH) ? DIV_CNT_W : cnt_width(WIDTH);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dividend;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dvz;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_start_ok;
  logic             w_dd_neg;
  logic             w_ds_neg;
  logic [WIDTH-1:0] w_dd_mag;
  logic [WIDTH-1:0] w_ds_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;
  logic [WIDTH-1:0] w_q_final;
  logic [WIDTH-1:0] w_r_final;

  assign w_start_ok = bus.start & ~bus.flush;
  assign w_dd_neg   = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_ds_neg   = bus.is_signed & bus.divisor[WIDTH-1];
  // Magnitudes are unsigned, so negating MIN yields 2^(WIDTH-1) as intended.
  assign w_dd_mag   = w_dd_neg ? -bus.dividend : bus.dividend;
  assign w_ds_mag   = w_ds_neg ? -bus.divisor  : bus.divisor;

  seq_divider_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_dq_msb (r_dq[WIDTH-1]),
    .i_dvs    (r_dvs),
    .o_rem    (w_step_rem),
    .o_q_bit  (w_step_q)
  );

  // Divide-by-zero reports all-ones and the untouched dividend, bypassing sign fix.
  assign w_q_final = r_dvz ? '1         : (r_neg_q ? -r_dq  : r_dq);
  assign w_r_final = r_dvz ? r_dividend : (r_neg_r ? -r_rem : r_rem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_dq          <= '0;
      r_dvs         <= '0;
      r_rem         <= '0;
      r_dividend    <= '0;
      r_neg_q       <= 1'b0;
      r_neg_r       <= 1'b0;
      r_dvz         <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_state    <= ST_CALC;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_dq       <= w_dd_mag;
            r_dvs      <= w_ds_mag;
            r_rem      <= '0;
            r_dividend <= bus.dividend;
            r_neg_q    <= w_dd_neg ^ w_ds_neg;
            r_neg_r    <= w_dd_neg;
            r_dvz      <= (bus.divisor == '0);
          end
        end
        ST_CALC: begin
          if (bus.flush) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_rem <= w_step_rem;
            r_dq  <= {r_dq[WIDTH-2:0], w_step_q};
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
              r_state <= ST_FIX;
            end
          end
        end
        ST_FIX: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (!bus.flush) begin
            r_done        <= 1'b1;
            r_quotient    <= w_q_final;
            r_remainder   <= w_r_final;
            r_div_by_zero <= r_dvz;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: latency, signed/unsigned results, divide by
// zero, overflow, ignored start, flush and asynchronous reset.
module tb_seq_divider;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
  endtask

  // Caller is at a negedge (cycle 0). Returns at the negedge of the done cycle.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input int inj,
                        output int lat, output int busy_cycles);
    drive(sgn, a, b);
    bus.start   = 1'b1;
    lat         = -1;
    busy_cycles = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (inj != 0 && k == inj) begin
        bus.start = 1'b1;
        drive(~sgn, 32'h0001_2345, 32'h0000_0003);
      end
      if (inj != 0 && k == inj + 1) bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    $display("op %s: signed=%b a=%h b=%h lat=%0d busy=%0d q=%h r=%h dbz=%b",
             tag, sgn, a, b, lat, busy_cycles, bus.quotient, bus.remainder, bus.div_by_zero);
  endtask

  task automatic op_check(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int inj, input logic [31:0] eq,
                          input logic [31:0] er, input logic ez);
    int lat;
    int bc;
    run_op(tag, sgn, a, b, inj, lat, bc);
    chk({tag, " latency"}, lat, 34);
    chk({tag, " busy_cycles"}, bc, 33);
    chk({tag, " quotient"}, bus.quotient, eq);
    chk({tag, " remainder"}, bus.remainder, er);
    chk({tag, " div_by_zero"}, {31'b0, bus.div_by_zero}, {31'b0, ez});
  endtask

  initial begin
    logic saw_done;
    int   lat;
    int   bc;

    bus.start = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, bus.busy}, 32'd0);
    chk("reset done", {31'b0, bus.done}, 32'd0);
    chk("reset quotient", bus.quotient, 32'd0);
    chk("reset remainder", bus.remainder, 32'd0);
    chk("reset dbz", {31'b0, bus.div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op_check("divu_100_7", 1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2, 1'b0);
    @(negedge clk);
    chk("done pulse width", {31'b0, bus.done}, 32'd0);
    chk("idle busy", {31'b0, bus.busy}, 32'd0);

    op_check("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    // Started in the done cycle of the previous op.
    op_check("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, 32'd1, 1'b0);
    op_check("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 32'd0, 1'b0);
    op_check("divu_5_0", 1'b0, 32'd5, 32'd0, 0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    op_check("divu_9_3", 1'b0, 32'd9, 32'd3, 0, 32'd3, 32'd0, 1'b0);
    op_check("div_m8_0", 1'b1, 32'hFFFF_FFF8, 32'd0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b1);
    op_check("divu_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 32'd1, 32'd1, 1'b0);
    op_check("divu_ignored_start", 1'b0, 32'd100, 32'd7, 10, 32'd14, 32'd2, 1'b0);
    @(negedge clk);

    // Flush mid-CALC: second start ignored, flush in cycle 20, nothing reported.
    saw_done = 1'b0;
    drive(1'b0, 32'd1000, 32'd10);
    bus.start = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1)  bus.start = 1'b0;
      if (k == 10) begin
        bus.start = 1'b1;
        drive(1'b0, 32'd50, 32'd5);
      end
      if (k == 11) bus.start = 1'b0;
      if (k == 20) bus.flush = 1'b1;
      if (k == 21) bus.flush = 1'b0;
      if (bus.done) saw_done = 1'b1;
    end
    $display("op flush: busy=%b saw_done=%b q=%h r=%h", bus.busy, saw_done, bus.quotient, bus.remainder);
    chk("flush busy", {31'b0, bus.busy}, 32'd0);
    chk("flush no done", {31'b0, saw_done}, 32'd0);
    chk("flush quotient kept", bus.quotient, 32'd14);
    chk("flush remainder kept", bus.remainder, 32'd2);
    @(negedge clk);
    run_op("after_flush_77_7", 1'b0, 32'd77, 32'd7, 0, lat, bc);
    chk("after_flush latency", lat, 34);
    chk("after_flush quotient", bus.quotient, 32'd11);
    chk("after_flush remainder", bus.remainder, 32'd0);
    @(negedge clk);

    // start and flush together in IDLE: not accepted.
    drive(1'b0, 32'd40, 32'd4);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    $display("op start_flush: busy=%b", bus.busy);
    chk("start_flush busy", {31'b0, bus.busy}, 32'd0);
    @(negedge clk);

    // Asynchronous reset mid-CALC.
    saw_done = 1'b0;
    drive(1'b0, 32'd100, 32'd3);
    bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    chk("pre_rst busy", {31'b0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("op async_rst: busy=%b done=%b q=%h r=%h", bus.busy, bus.done, bus.quotient, bus.remainder);
    chk("rst busy", {31'b0, bus.busy}, 32'd0);
    chk("rst done", {31'b0, bus.done}, 32'd0);
    chk("rst quotient", bus.quotient, 32'd0);
    chk("rst remainder", bus.remainder, 32'd0);
    #1 rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    chk("rst no done", {31'b0, saw_done}, 32'd0);
    chk("rst idle busy", {31'b0, bus.busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
